// File: rtl/sram_ctrl_pkg.sv
// Shared types and sizing helpers for the SRAM burst controller.
package sram_ctrl_pkg;

   // Controller states
   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRd   = 2'd1,
      StWr   = 2'd2,
      StDone = 2'd3
   } state_e;

   // CPU byte address that maps onto SRAM word 0 unless overridden
   localparam int unsigned DefaultBaseAddr = 32'd1024;

   // SRAM beats needed to move one CPU write word
   function automatic int unsigned beats_per_write(input int unsigned data_w,
                                                   input int unsigned sram_dw);
      return data_w / sram_dw;
   endfunction

   // log2 of the read burst length (burst length is a power of two)
   function automatic int unsigned burst_log2(input int unsigned burst_words);
      return $clog2(burst_words);
   endfunction

   // log2 of bytes per SRAM word: byte address to word address shift
   function automatic int unsigned byte_shift(input int unsigned sram_dw);
      return $clog2(sram_dw / 8);
   endfunction

   // Counter width able to index n items, never narrower than one bit
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sram_burst_ctrl_if.sv
// Request/response bus between the cache stage and the SRAM burst controller.
// With SRAM_BYTE_MASK_EN defined the bus also carries per-byte write enables.
interface sram_burst_ctrl_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned LINE_W = 64
) ();

   localparam int unsigned BeW = DATA_W / 8;

   logic              rd_en;
   logic              wr_en;
   logic [ADDR_W-1:0] address;
   logic [DATA_W-1:0] write_data;
   logic [LINE_W-1:0] read_data;
   logic              ready;
   logic              busy;
`ifdef SRAM_BYTE_MASK_EN
   logic [BeW-1:0]    byte_en;

   modport master (
      output rd_en, wr_en, address, write_data, byte_en,
      input  read_data, ready, busy
   );

   modport slave (
      input  rd_en, wr_en, address, write_data, byte_en,
      output read_data, ready, busy
   );
`else
   modport master (
      output rd_en, wr_en, address, write_data,
      input  read_data, ready, busy
   );

   modport slave (
      input  rd_en, wr_en, address, write_data,
      output read_data, ready, busy
   );
`endif

endinterface

// File: rtl/sram_beat_timer.sv
// Beat and wait-state counters shared by the read and write bursts.
// Counters sit at zero whenever run is low.
module sram_beat_timer #(
   parameter int unsigned BEAT_W      = 2,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   input  logic [BEAT_W-1:0] last_beat,
   output logic [BEAT_W-1:0] beat_idx,
   output logic              beat_last_cycle,
   output logic              burst_done
);

   localparam logic [3:0] WsMax = 4'(WAIT_STATES);

   logic [BEAT_W-1:0] beat_q;
   logic [3:0]        ws_q;

   assign beat_idx        = beat_q;
   assign beat_last_cycle = run && (ws_q == WsMax);
   assign burst_done      = beat_last_cycle && (beat_q == last_beat);

   // Advance wait counter each cycle, step beat when a beat's last cycle ends
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         beat_q <= '0;
         ws_q   <= '0;
      end else if (!run) begin
         beat_q <= '0;
         ws_q   <= '0;
      end else if (ws_q == WsMax) begin
         ws_q   <= '0;
         beat_q <= burst_done ? '0 : beat_q + 1'b1;
      end else begin
         ws_q   <= ws_q + 1'b1;
      end
   end

endmodule

// File: rtl/sram_burst_ctrl.sv
// Controller for an asynchronous single-port SRAM: line-sized burst reads and
// CPU-word writes split into SRAM beats, each beat WAIT_STATES+1 cycles long.
// Optional feature macro: SRAM_BYTE_MASK_EN (per-byte write enables).
module sram_burst_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned SRAM_DW     = 16,
   parameter int unsigned SRAM_AW     = 18,
   parameter int unsigned BURST_WORDS = 4,
   parameter int unsigned BASE_ADDR   = DefaultBaseAddr,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic                clk,
   input  logic                rst,
   sram_burst_ctrl_if.slave    bus,
   inout  wire  [SRAM_DW-1:0]  SRAM_DQ,
   output logic [SRAM_AW-1:0]  SRAM_ADDR,
   output logic                SRAM_UB_N,
   output logic                SRAM_LB_N,
   output logic                SRAM_CE_N,
   output logic                SRAM_OE_N,
   output logic                SRAM_WE_N
);

   localparam int unsigned WrBeats  = beats_per_write(DATA_W, SRAM_DW);
   localparam int unsigned MaxBeats = (BURST_WORDS > WrBeats) ? BURST_WORDS : WrBeats;
   localparam int unsigned BeatW    = cnt_width(MaxBeats);
   localparam int unsigned ByteSh   = byte_shift(SRAM_DW);
   localparam int unsigned LineW    = SRAM_DW * BURST_WORDS;
   localparam int unsigned BeW      = DATA_W / 8;
   localparam int unsigned BytesPw  = SRAM_DW / 8;

   localparam logic [SRAM_AW-1:0] RdMask  = SRAM_AW'((1 << burst_log2(BURST_WORDS)) - 1);
   localparam logic [SRAM_AW-1:0] WrMask  = SRAM_AW'((1 << $clog2(WrBeats)) - 1);
   localparam logic [BeatW-1:0]   RdLast  = BeatW'(BURST_WORDS - 1);
   localparam logic [BeatW-1:0]   WrLast  = BeatW'(WrBeats - 1);
   localparam logic [ADDR_W-1:0]  BaseAdr = ADDR_W'(BASE_ADDR);

   state_e              state_q;
   logic                ready_q;
   logic                busy_q;
   logic [LineW-1:0]    read_data_q;
   logic [SRAM_AW-1:0]  widx_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [BeW-1:0]      be_q;

   logic [ADDR_W-1:0]   off;
   logic [SRAM_AW-1:0]  widx_d;
   logic [BeW-1:0]      be_d;

   logic                run;
   logic [BeatW-1:0]    last_beat;
   logic [BeatW-1:0]    beat_idx;
   logic                beat_last_cycle;
   logic                burst_done;

   logic [SRAM_AW-1:0]  sram_addr_c;
   logic                oe_n_c;
   logic                we_n_c;
   logic                ub_n_c;
   logic                lb_n_c;
   logic                dq_oe_c;
   logic [SRAM_DW-1:0]  dq_out_c;
   logic [BytesPw-1:0]  beat_be;

   // Address arithmetic wraps; out-of-range addresses simply alias into SRAM
   assign off    = bus.address - BaseAdr;
   assign widx_d = SRAM_AW'(off >> ByteSh);

`ifdef SRAM_BYTE_MASK_EN
   assign be_d = bus.byte_en;
`else
   assign be_d = '1;
`endif

   assign run       = (state_q == StRd) || (state_q == StWr);
   assign last_beat = (state_q == StRd) ? RdLast : WrLast;

   sram_beat_timer #(
      .BEAT_W      (BeatW),
      .WAIT_STATES (WAIT_STATES)
   ) u_timer (
      .clk             (clk),
      .rst             (rst),
      .run             (run),
      .last_beat       (last_beat),
      .beat_idx        (beat_idx),
      .beat_last_cycle (beat_last_cycle),
      .burst_done      (burst_done)
   );

   // Request FSM: latch on acceptance, capture read beats, pulse ready in DONE
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         ready_q     <= 1'b0;
         busy_q      <= 1'b0;
         read_data_q <= '0;
         widx_q      <= '0;
         wdata_q     <= '0;
         be_q        <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               ready_q <= 1'b0;
               if (bus.wr_en || bus.rd_en) begin
                  // Write has priority when both requests are present
                  state_q <= bus.wr_en ? StWr : StRd;
                  busy_q  <= 1'b1;
                  widx_q  <= widx_d;
                  wdata_q <= bus.write_data;
                  be_q    <= be_d;
               end
            end
            StRd: begin
               if (beat_last_cycle) begin
                  read_data_q[int'(beat_idx)*SRAM_DW +: SRAM_DW] <= SRAM_DQ;
               end
               if (burst_done) begin
                  state_q <= StDone;
                  ready_q <= 1'b1;
               end
            end
            StWr: begin
               if (burst_done) begin
                  state_q <= StDone;
                  ready_q <= 1'b1;
               end
            end
            StDone: begin
               state_q <= StIdle;
               ready_q <= 1'b0;
               busy_q  <= 1'b0;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // SRAM pin decode from the registered state and beat counters
   always_comb begin
      sram_addr_c = widx_q;
      oe_n_c      = 1'b1;
      we_n_c      = 1'b1;
      ub_n_c      = 1'b0;
      lb_n_c      = 1'b0;
      dq_oe_c     = 1'b0;
      dq_out_c    = '0;
      beat_be     = be_q[int'(beat_idx)*BytesPw +: BytesPw];
      unique case (state_q)
         StRd: begin
            // Line-aligned sequential burst
            sram_addr_c = (widx_q & ~RdMask) | SRAM_AW'(beat_idx);
            oe_n_c      = 1'b0;
         end
         StWr: begin
            sram_addr_c = (widx_q & ~WrMask) + SRAM_AW'(beat_idx);
            dq_oe_c     = 1'b1;
            dq_out_c    = wdata_q[int'(beat_idx)*SRAM_DW +: SRAM_DW];
            // Last cycle of a multi-cycle beat releases WE_N for address/data hold;
            // single-cycle beats rely on DONE for the release
            we_n_c      = (WAIT_STATES == 0) ? 1'b0 : beat_last_cycle;
`ifdef SRAM_BYTE_MASK_EN
            lb_n_c      = ~beat_be[0];
            ub_n_c      = ~beat_be[BytesPw-1];
            if (beat_be == '0) begin
               we_n_c = 1'b1;
            end
`endif
         end
         default: begin
         end
      endcase
   end

   assign SRAM_DQ   = dq_oe_c ? dq_out_c : {SRAM_DW{1'bz}};
   assign SRAM_ADDR = sram_addr_c;
   assign SRAM_OE_N = oe_n_c;
   assign SRAM_WE_N = we_n_c;
   assign SRAM_UB_N = ub_n_c;
   assign SRAM_LB_N = lb_n_c;
   assign SRAM_CE_N = 1'b0;

   assign bus.read_data = read_data_q;
   assign bus.ready     = ready_q;
   assign bus.busy      = busy_q;

endmodule

// File: tb/tb_sram_burst_ctrl.sv
// Directed bench for sram_burst_ctrl: default-timing instance plus a
// WAIT_STATES=2 instance, each attached to a small behavioural SRAM.
module tb_sram_burst_ctrl;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   sram_burst_ctrl_if #(.ADDR_W(32), .DATA_W(32), .LINE_W(64)) bus0 ();
   sram_burst_ctrl_if #(.ADDR_W(32), .DATA_W(32), .LINE_W(64)) bus1 ();

   wire  [15:0] dq0;
   wire  [15:0] dq1;
   logic [17:0] sa0, sa1;
   logic        ub0, lb0, ce0, oe0, we0;
   logic        ub1, lb1, ce1, oe1, we1;

   sram_burst_ctrl #(.WAIT_STATES(0)) u_dut0 (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus0),
      .SRAM_DQ   (dq0),
      .SRAM_ADDR (sa0),
      .SRAM_UB_N (ub0),
      .SRAM_LB_N (lb0),
      .SRAM_CE_N (ce0),
      .SRAM_OE_N (oe0),
      .SRAM_WE_N (we0)
   );

   sram_burst_ctrl #(.WAIT_STATES(2)) u_dut1 (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus1),
      .SRAM_DQ   (dq1),
      .SRAM_ADDR (sa1),
      .SRAM_UB_N (ub1),
      .SRAM_LB_N (lb1),
      .SRAM_CE_N (ce1),
      .SRAM_OE_N (oe1),
      .SRAM_WE_N (we1)
   );

   // Behavioural SRAMs (256 words, upper address bits alias)
   logic [15:0] mem0 [256];
   logic [15:0] mem1 [256];
   logic        pl_en;
   logic [7:0]  pl_addr;
   logic [15:0] pl_data;

   assign dq0 = (!ce0 && !oe0 && we0) ? mem0[sa0[7:0]] : 16'hzzzz;
   assign dq1 = (!ce1 && !oe1 && we1) ? mem1[sa1[7:0]] : 16'hzzzz;

   always @(posedge clk) begin
      if (pl_en) begin
         mem0[pl_addr] <= pl_data;
         mem1[pl_addr] <= pl_data;
      end else begin
         if (!ce0 && !we0) begin
            if (!lb0) mem0[sa0[7:0]][7:0]  <= dq0[7:0];
            if (!ub0) mem0[sa0[7:0]][15:8] <= dq0[15:8];
         end
         if (!ce1 && !we1) begin
            if (!lb1) mem1[sa1[7:0]][7:0]  <= dq1[7:0];
            if (!ub1) mem1[sa1[7:0]][15:8] <= dq1[15:8];
         end
      end
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic preload(input logic [7:0] a, input logic [15:0] d);
      @(negedge clk);
      pl_en   = 1'b1;
      pl_addr = a;
      pl_data = d;
      @(negedge clk);
      pl_en   = 1'b0;
   endtask

   // Present a request on bus0 for exactly one acceptance edge
   task automatic req0(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d);
      @(negedge clk);
      bus0.rd_en      = rd;
      bus0.wr_en      = wr;
      bus0.address    = a;
      bus0.write_data = d;
      @(posedge clk);
      #1;
      bus0.rd_en = 1'b0;
      bus0.wr_en = 1'b0;
   endtask

   // Cycle k after acceptance is sampled on the k-th following negedge
   task automatic wait_ready0(input string tag, input int exp_cyc);
      int cyc;
      bit seen;
      cyc  = 0;
      seen = 1'b0;
      for (int k = 1; k <= 40 && !seen; k++) begin
         @(negedge clk);
         if (bus0.ready) begin
            seen = 1'b1;
            cyc  = k;
         end
      end
      check_eq(tag, 64'(cyc), 64'(exp_cyc));
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bit saw;
      rst             = 1'b1;
      pl_en           = 1'b0;
      pl_addr         = '0;
      pl_data         = '0;
      bus0.rd_en      = 1'b0;
      bus0.wr_en      = 1'b0;
      bus0.address    = '0;
      bus0.write_data = '0;
      bus1.rd_en      = 1'b0;
      bus1.wr_en      = 1'b0;
      bus1.address    = '0;
      bus1.write_data = '0;
`ifdef SRAM_BYTE_MASK_EN
      bus0.byte_en    = 4'hF;
      bus1.byte_en    = 4'hF;
`endif

      // Reset state
      @(negedge clk);
      check_eq("rst_busy",  64'(bus0.busy), 64'd0);
      check_eq("rst_ready", 64'(bus0.ready), 64'd0);
      check_eq("rst_rdata", bus0.read_data, 64'd0);
      check_eq("rst_strb",  64'({we0, oe0, ce0, ub0, lb0}), 64'b11000);
      rst = 1'b0;

      preload(8'd0, 16'h000A);
      preload(8'd1, 16'h000B);
      preload(8'd2, 16'h000C);
      preload(8'd3, 16'h000D);
      preload(8'd4, 16'h1111);
      preload(8'd5, 16'h2222);
      preload(8'd6, 16'h3333);
      preload(8'd7, 16'h4444);

      // Burst read at 0x408: words 4..7
      req0(1'b1, 1'b0, 32'h408, 32'h0);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         check_eq("rd_addr",  64'(sa0), 64'(3 + k));
         check_eq("rd_strb",  64'({oe0, we0, ub0, lb0}), 64'b0100);
         check_eq("rd_ready", 64'(bus0.ready), 64'd0);
      end
      @(negedge clk);
      check_eq("rd_ready5", 64'(bus0.ready), 64'd1);
      check_eq("rd_busy5",  64'(bus0.busy), 64'd1);
      check_eq("rd_line",   bus0.read_data, 64'h4444_3333_2222_1111);
      @(negedge clk);
      check_eq("rd_ready6", 64'(bus0.ready), 64'd0);
      check_eq("rd_busy6",  64'(bus0.busy), 64'd0);

      // Write 0xDEADBEEF at 0x404; request inputs scrambled right after acceptance
      req0(1'b0, 1'b1, 32'h404, 32'hDEAD_BEEF);
      bus0.address    = 32'hFFFF_FFF0;
      bus0.write_data = 32'h0;
      @(negedge clk);
      check_eq("wr0_addr", 64'(sa0), 64'd2);
      check_eq("wr0_dq",   64'(dq0), 64'h BEEF);
      check_eq("wr0_strb", 64'({we0, oe0}), 64'b01);
      @(negedge clk);
      check_eq("wr1_addr", 64'(sa0), 64'd3);
      check_eq("wr1_dq",   64'(dq0), 64'h DEAD);
      check_eq("wr1_we",   64'(we0), 64'd0);
      @(negedge clk);
      check_eq("wr_ready3", 64'(bus0.ready), 64'd1);
      check_eq("wr_we3",    64'(we0), 64'd1);

      req0(1'b1, 1'b0, 32'h400, 32'h0);
      wait_ready0("rb0_lat", 5);
      check_eq("rb0_line", bus0.read_data, 64'hDEAD_BEEF_000B_000A);

      // rd_en and wr_en together: write wins, OE_N never asserted
      req0(1'b1, 1'b1, 32'h408, 32'h5555_6666);
      saw = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         if (!oe0) saw = 1'b1;
         if (k == 3) check_eq("both_ready3", 64'(bus0.ready), 64'd1);
      end
      check_eq("both_no_oe", 64'(saw), 64'd0);
      req0(1'b1, 1'b0, 32'h408, 32'h0);
      wait_ready0("rb1_lat", 5);
      check_eq("rb1_line", bus0.read_data, 64'h4444_3333_5555_6666);

      // Asynchronous reset during beat 2 of a read
      req0(1'b1, 1'b0, 32'h400, 32'h0);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      check_eq("mid_addr", 64'(sa0), 64'd2);
      rst = 1'b1;
      #1;
      check_eq("mid_busy",  64'(bus0.busy), 64'd0);
      check_eq("mid_ready", 64'(bus0.ready), 64'd0);
      check_eq("mid_strb",  64'({we0, oe0}), 64'b11);
      check_eq("mid_rdata", bus0.read_data, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      saw = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (bus0.ready) saw = 1'b1;
      end
      check_eq("mid_no_ready", 64'(saw), 64'd0);
      req0(1'b1, 1'b0, 32'h408, 32'h0);
      wait_ready0("post_rst_lat", 5);
      check_eq("post_rst_line", bus0.read_data, 64'h4444_3333_5555_6666);

      // WAIT_STATES = 2 instance: read at 0x400, 3 cycles per beat
      @(negedge clk);
      bus1.rd_en   = 1'b1;
      bus1.address = 32'h400;
      @(posedge clk);
      #1;
      bus1.rd_en = 1'b0;
      for (int k = 1; k <= 13; k++) begin
         @(negedge clk);
         if (k <= 12) check_eq("ws_addr", 64'(sa1), 64'((k - 1) / 3));
         check_eq("ws_ready", 64'(bus1.ready), 64'(k == 13));
         if (k == 3) check_eq("ws_cap_pre",  64'(bus1.read_data[15:0]), 64'h0);
         if (k == 4) check_eq("ws_cap_post", 64'(bus1.read_data[15:0]), 64'h000A);
      end
      check_eq("ws_line", bus1.read_data, 64'h000D_000C_000B_000A);

`ifdef SRAM_BYTE_MASK_EN
      // Byte mask: only byte 2 of the word is written
      @(negedge clk);
      bus0.byte_en = 4'b0100;
      req0(1'b0, 1'b1, 32'h400, 32'h1234_5678);
      bus0.byte_en = 4'hF;
      @(negedge clk);
      check_eq("bm0_we", 64'(we0), 64'd1);
      @(negedge clk);
      check_eq("bm1_addr", 64'(sa0), 64'd1);
      check_eq("bm1_strb", 64'({we0, ub0, lb0}), 64'b010);
      req0(1'b1, 1'b0, 32'h400, 32'h0);
      wait_ready0("bm_rb_lat", 5);
      check_eq("bm_rb_line", bus0.read_data, 64'hDEAD_BEEF_0034_000A);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
